// File: rtl/fir_out_requant.sv
// FIR output requantiser: decimates 64-bit filter results, rounds/saturates to 16-bit samples
// and buffers them in a show-ahead FIFO. Define REQUANT_CONV_ROUND_EN for ties-to-even rounding.
module fir_out_requant #(
    parameter int unsigned IN_W       = 64,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned SHIFT      = 15,
    parameter int unsigned DECIM      = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic                          sat_pulse,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LW   = AW + 1;

    localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [PH_W-1:0]  phase;
    logic             stage_valid;
    logic [OUT_W-1:0] stage_data;
    logic             stage_sat;
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic                    keep_c;
    logic signed [IN_W:0]    sum_c;
    logic signed [IN_W:0]    rnd_c;
    logic [OUT_W-1:0]        q_c;
    logic                    sat_c;
    logic                    pop_c;
    logic                    push_c;
    logic                    drop_c;
    logic [AW-1:0]           rd_nxt;
    logic [LW-1:0]           lvl_nxt;
    logic [OUT_W-1:0]        head_nxt;

    assign keep_c = in_valid && (phase == '0);

    // Round (extra top bit keeps the bias add from wrapping), then saturate to OUT_W
    always_comb begin
        sum_c = $signed({in_data[IN_W-1], in_data}) + $signed(HALF);
        rnd_c = sum_c >>> SHIFT;
`ifdef REQUANT_CONV_ROUND_EN
        // exact tie with an even floor: undo the bias increment
        if ((in_data[SHIFT-1:0] == HALF[SHIFT-1:0]) && !in_data[SHIFT])
            rnd_c = rnd_c - (IN_W+1)'(1);
`endif
        q_c   = rnd_c[OUT_W-1:0];
        sat_c = 1'b0;
        if (rnd_c > SAT_MAX) begin
            q_c   = SAT_MAX[OUT_W-1:0];
            sat_c = 1'b1;
        end else if (rnd_c < SAT_MIN) begin
            q_c   = SAT_MIN[OUT_W-1:0];
            sat_c = 1'b1;
        end
    end

    // FIFO next-state; a full FIFO still accepts a write when the head pops on the same edge
    always_comb begin
        pop_c   = out_valid && out_ready;
        push_c  = stage_valid && ((fifo_level != LW'(FIFO_DEPTH)) || pop_c);
        drop_c  = stage_valid && !push_c;
        rd_nxt  = pop_c ? rd_ptr + AW'(1) : rd_ptr;
        lvl_nxt = fifo_level;
        case ({push_c, pop_c})
            2'b10:   lvl_nxt = fifo_level + LW'(1);
            2'b01:   lvl_nxt = fifo_level - LW'(1);
            default: lvl_nxt = fifo_level;
        endcase
        if (lvl_nxt == '0)
            head_nxt = '0;
        else if (push_c && (wr_ptr == rd_nxt))
            head_nxt = stage_data;
        else
            head_nxt = mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            stage_sat   <= 1'b0;
            sat_pulse   <= 1'b0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            if (in_valid)
                phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
            stage_valid <= keep_c;
            if (keep_c) begin
                stage_data <= q_c;
                stage_sat  <= sat_c;
            end
            sat_pulse <= stage_valid && stage_sat;
            if (drop_c)
                overflow <= 1'b1;
            if (push_c)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_nxt;
            fifo_level <= lvl_nxt;
            out_valid  <= (lvl_nxt != '0);
            out_data   <= head_nxt;
        end
    end

    // Sample storage needs no reset: contents are only visible through fifo_level/out_valid
    always_ff @(posedge clk) begin
        if (push_c)
            mem[wr_ptr] <= stage_data;
    end

endmodule
